// File: rtl/motor_ramp_ctrl_pkg.sv
// motor_ramp_ctrl shared types: duty width, FSM encoding, saturation
// constant and the magnitude helpers used by the ramp datapath.
package motor_ramp_ctrl_pkg;

  localparam int DUTY_CYCLE_SIZE = 10;
  localparam int CMD_W = DUTY_CYCLE_SIZE + 1;

  typedef logic [DUTY_CYCLE_SIZE-1:0] duty_t;

  localparam duty_t DUTY_SAT = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAMP,
    ST_HOLD,
    ST_DWELL
  } state_e;

  // Most-negative input has no positive twin; clamp it to full scale.
  function automatic duty_t sat_abs(input logic [CMD_W-1:0] v);
    logic [CMD_W-1:0] a;
    a = v[CMD_W-1] ? (~v + 1'b1) : v;
    if (a[CMD_W-1]) return DUTY_SAT;
    return a[CMD_W-2:0];
  endfunction

  function automatic duty_t step_toward(
    input duty_t mag,
    input duty_t tgt,
    input duty_t step
  );
    duty_t diff;
    if (mag < tgt) begin
      diff = tgt - mag;
      return mag + ((diff > step) ? step : diff);
    end
    diff = mag - tgt;
    return mag - ((diff > step) ? step : diff);
  endfunction

endpackage

// File: rtl/motor_ramp_ctrl_ramp_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks.
// DIV must be at least 1; DIV=1 ticks on every cycle.
module ramp_tick_gen #(
  parameter int DIV = 5000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Slew-limited H-bridge speed ramp with dwell-at-zero on reversal.
// Optional command watchdog enabled by defining CMD_WATCHDOG_EN.
module motor_ramp_ctrl
  import motor_ramp_ctrl_pkg::*;
#(
  parameter int RAMP_DIV    = 5000,
  parameter int RAMP_STEP   = 4,
  parameter int ZERO_HOLD   = 50000,
  parameter int WDOG_CYCLES = 25000000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [DUTY_CYCLE_SIZE:0]   cmd_speed,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  output logic                       dir,
  output logic                       on,
  output logic [DUTY_CYCLE_SIZE-1:0] duty_cycle,
  output logic                       wdog_trip
);

  localparam int ZW = $clog2(ZERO_HOLD + 1);
  localparam logic [ZW-1:0] ZH_LAST = ZW'(ZERO_HOLD - 1);
  localparam duty_t STEP_W =
    (RAMP_STEP >= (1 << DUTY_CYCLE_SIZE)) ? DUTY_SAT : duty_t'(RAMP_STEP);

  state_e          state_q, state_d;
  duty_t           mag_q, mag_d;
  duty_t           tgt_mag_q, tgt_mag_d;
  duty_t           eff;
  logic            dir_q, dir_d;
  logic            tgt_dir_q, tgt_dir_d;
  logic            on_q, on_d;
  logic            rdy_q, rdy_d;
  logic [ZW-1:0]   dwell_q, dwell_d;
  logic            tick, accept, cmd_zero, cmd_pos, pending;

`ifdef CMD_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(WDOG_CYCLES - 1);
  logic [WW-1:0] wdog_q, wdog_d;
  logic          trip_q, trip_d;
`endif

  ramp_tick_gen #(
    .DIV(RAMP_DIV)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick)
  );

  always_comb begin
    accept    = cmd_valid & rdy_q;
    cmd_zero  = (cmd_speed == '0);
    cmd_pos   = ~cmd_speed[DUTY_CYCLE_SIZE];
    tgt_mag_d = tgt_mag_q;
    tgt_dir_d = tgt_dir_q;
    if (accept) begin
      tgt_mag_d = sat_abs(cmd_speed);
      if (!cmd_zero) tgt_dir_d = cmd_pos;
    end
`ifdef CMD_WATCHDOG_EN
    wdog_d = wdog_q;
    trip_d = trip_q;
    if (accept) begin
      wdog_d = '0;
      trip_d = 1'b0;
    end else if (!trip_q) begin
      if (wdog_q == WD_LAST) begin
        trip_d    = 1'b1;
        wdog_d    = '0;
        tgt_mag_d = '0;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
`endif
    // A pending reversal ramps to zero before the new magnitude applies.
    pending = (tgt_dir_q != dir_q);
    eff     = pending ? '0 : tgt_mag_q;
    state_d = state_q;
    mag_d   = mag_q;
    dir_d   = dir_q;
    dwell_d = dwell_q;
    unique case (1'b1)
      (state_q == ST_DWELL): begin
        if (dwell_q == ZH_LAST) begin
          dwell_d = '0;
          dir_d   = ~dir_q;
          state_d = ST_RAMP;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      default: begin
        if (state_q == ST_IDLE && accept && !cmd_zero)
          dir_d = cmd_pos;
        if (tick)
          mag_d = step_toward(mag_q, eff, STEP_W);
        if (mag_d == '0 && pending)
          state_d = ST_DWELL;
        else if (mag_d == eff)
          state_d = (mag_d == '0) ? ST_IDLE : ST_HOLD;
        else
          state_d = ST_RAMP;
      end
    endcase
    on_d  = (mag_d != '0);
    rdy_d = (state_d != ST_DWELL);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      mag_q     <= '0;
      tgt_mag_q <= '0;
      dir_q     <= 1'b1;
      tgt_dir_q <= 1'b1;
      on_q      <= 1'b0;
      rdy_q     <= 1'b1;
      dwell_q   <= '0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      tgt_mag_q <= tgt_mag_d;
      dir_q     <= dir_d;
      tgt_dir_q <= tgt_dir_d;
      on_q      <= on_d;
      rdy_q     <= rdy_d;
      dwell_q   <= dwell_d;
    end
  end

`ifdef CMD_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wdog_q <= '0;
      trip_q <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      trip_q <= trip_d;
    end
  end
  assign wdog_trip = trip_q;
`else
  // Constant-false term keeps the watchdog parameter referenced.
  assign wdog_trip = (WDOG_CYCLES < 0);
`endif

  assign cmd_ready  = rdy_q;
  assign dir        = dir_q;
  assign on         = on_q;
  assign duty_cycle = mag_q;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl (DIV=4, STEP=8, HOLD=16, WDOG=200).
// Watchdog scenario follows CMD_WATCHDOG_EN.
module tb_motor_ramp_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] cmd_speed;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        dir;
  logic        on;
  logic [9:0]  duty_cycle;
  logic        wdog_trip;

  int n_assert = 0;
  int n_fail   = 0;

  motor_ramp_ctrl #(
    .RAMP_DIV   (4),
    .RAMP_STEP  (8),
    .ZERO_HOLD  (16),
    .WDOG_CYCLES(200)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_speed (cmd_speed),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .dir       (dir),
    .on        (on),
    .duty_cycle(duty_cycle),
    .wdog_trip (wdog_trip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cmd(input int v);
    cmd_speed = 11'(v);
    cmd_valid = 1'b1;
  endtask

  task automatic wait_change(output int gap);
    logic [9:0] prev;
    prev = duty_cycle;
    gap  = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (duty_cycle == prev && gap < 60);
  endtask

  // Expected ramp: step of at most 8 toward target, one change per 4 clocks.
  task automatic ramp_seq(input string tag, input int from, input int to);
    int e, gap, k;
    e = from;
    k = 0;
    while (e != to) begin
      if (e < to) e = (to - e > 8) ? e + 8 : to;
      else        e = (e - to > 8) ? e - 8 : to;
      wait_change(gap);
      chk({tag, "_duty"}, int'(duty_cycle), e);
      if (k > 0) chk({tag, "_gap"}, gap, 4);
      k++;
    end
  endtask

  initial begin
    int n;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_speed = '0;
    cyc(3);
    chk("rst_duty", int'(duty_cycle), 0);
    chk("rst_on", int'(on), 0);
    chk("rst_dir", int'(dir), 1);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_trip", int'(wdog_trip), 0);

    reset_n = 1'b1;
    cmd(100);
    ramp_seq("up100", 0, 100);
    chk("up100_dir", int'(dir), 1);
    cyc(12);
    chk("hold100_duty", int'(duty_cycle), 100);
    chk("hold100_on", int'(on), 1);
    chk("hold100_ready", int'(cmd_ready), 1);

    cmd(-40);
    ramp_seq("rev_down", 100, 0);
    chk("rev_on", int'(on), 0);
    chk("rev_dir_kept", int'(dir), 1);
    n = 0;
    while (cmd_ready == 1'b0 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("dwell_len", n, 16);
    chk("rev_dir", int'(dir), 0);
    ramp_seq("rev_up", 0, 40);
    chk("rev_on2", int'(on), 1);

    cmd(-1024);
    ramp_seq("sat_up", 40, 1023);
    cyc(10);
    chk("sat_duty", int'(duty_cycle), 1023);
    cmd(0);
    ramp_seq("zero_down", 1023, 0);
    cyc(10);
    chk("idle_duty", int'(duty_cycle), 0);
    chk("idle_on", int'(on), 0);
    chk("idle_dir", int'(dir), 0);
    chk("idle_ready", int'(cmd_ready), 1);

    cmd(-16);
    ramp_seq("m16", 0, 16);
    cmd(8);
    ramp_seq("m16_down", 16, 0);
    chk("dw_ready", int'(cmd_ready), 0);
    cyc(5);
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mrst_duty", int'(duty_cycle), 0);
    chk("mrst_dir", int'(dir), 1);
    chk("mrst_ready", int'(cmd_ready), 1);
    chk("mrst_on", int'(on), 0);
    reset_n = 1'b1;
    cyc(30);
    chk("post_rst_dir", int'(dir), 1);
    chk("post_rst_duty", int'(duty_cycle), 0);

    cmd(-24);
    @(negedge clk);
    chk("idle_rev_dir", int'(dir), 0);
    chk("idle_rev_ready", int'(cmd_ready), 1);
    ramp_seq("m24", 0, 24);

    cmd(64);
    ramp_seq("p64_down", 24, 0);
    ramp_seq("p64_up", 0, 64);
    chk("p64_dir", int'(dir), 1);
    cmd_valid = 1'b0;
`ifdef CMD_WATCHDOG_EN
    n = 0;
    while (wdog_trip == 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wd_trip", int'(wdog_trip), 1);
    chk("wd_delay_ok", int'(n >= 198 && n <= 202), 1);
    ramp_seq("wd_down", 64, 0);
    chk("wd_on", int'(on), 0);
    cmd(16);
    @(negedge clk);
    chk("wd_clear", int'(wdog_trip), 0);
    ramp_seq("wd_up", 0, 16);
    chk("wd_dir", int'(dir), 1);
`else
    cyc(250);
    chk("nowd_duty", int'(duty_cycle), 64);
    chk("nowd_trip", int'(wdog_trip), 0);
    chk("nowd_on", int'(on), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
